stencil_dma_seq: RTL and testbench
==================================

# stencil_dma_seq

Row-sequencing DMA controller placed in front of the AXI FIFO interface in the stencil coprocessor. It accepts one 2-D transfer descriptor (source/destination base, per-row stride, row length, row count) and issues one read request and one write request per row over the FIFO interface's request ports. Write rows lag read rows by a configurable margin. DONE pulses once the FIFO interface reports idle.

## Interface
- WR_LAG, 0: write row i is not requested until read rows 0..i+WR_LAG have been requested.
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  descriptor strobe; sampled only in IDLE.
- SRC_ADDR / DST_ADDR  in  32 each  byte base of row 0.
- SRC_STRIDE / DST_STRIDE  in  32 each  byte step between rows.
- ROW_WORDS  in  16  words per row.
- ROWS  in  16  row count.
- BUSY  out  1  high from the cycle after START acceptance through the DONE cycle.
- DONE  out  1  single-cycle completion pulse.
- READ_ADDR  out  32  read request address.
- READ_COUNT  out  16  read request length.
- READ_REQ  out  1  read request strobe.
- READ_BUSY  in  1  read request port busy.
- WRITE_ADDR  out  32  write request address.
- WRITE_COUNT  out  16  write request length.
- WRITE_REQ  out  1  write request strobe.
- WRITE_BUSY  in  1  write request port busy.
- FIFO_BUSY  in  1  FIFO interface has outstanding work.
- CYCLES  out  32  transfer cycle count; see Configuration.

## Operation
- Top FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE: START=1 latches all descriptor inputs.
  - ROWS==0 or ROW_WORDS==0: go to FIN.
  - Otherwise: go to RUN.
- START is ignored in every state other than IDLE.
- RUN: the read issuer and write issuer run independently. RUN moves to DRAIN when both issuers have issued ROWS requests.
- DRAIN: wait until READ_BUSY, WRITE_BUSY and FIFO_BUSY are all 0, then go to FIN.
- FIN: DONE=1 and BUSY=1 for one cycle, then go to IDLE.
- Each issuer has states I_IDLE, I_REQ, I_WAIT.
  - I_REQ: REQ=1 for exactly one cycle, carrying ADDR = current row address and COUNT = ROW_WORDS.
  - I_WAIT: the port's BUSY is high on the cycle after REQ by construction. Leave I_WAIT on the first cycle BUSY==0.
  - Leaving I_WAIT: increment the issued count. Advance the row address by the stride (32-bit add, wraps mod 2^32). Then go to I_REQ if more rows remain and the issuer is eligible; otherwise go to I_IDLE.
- Read issuer is always eligible.
- Write issuer is eligible when rd_issued > wr_issued + WR_LAG, or when rd_issued == ROWS.
- Counters are 16-bit. The comparison is done in 17 bits so wr_issued + WR_LAG cannot overflow.
- REQ is never asserted while the matching BUSY input is 1, and never on two consecutive cycles.
- Reset values: all outputs 0; FSMs in IDLE / I_IDLE; counters 0.
- RST asserted mid-transfer aborts on the next edge with no further REQ. The FIFO interface is reset by its own reset.

## Timing
- START accepted at cycle t:
  - BUSY=1 at t+1.
  - First READ_REQ at t+1.
- First WRITE_REQ no earlier than the cycle after READ_BUSY falls for read row WR_LAG.
- Zero-length descriptor: DONE=1 at t+1, and no REQ is issued.
- DRAIN observes all busy inputs low at cycle d: DONE=1 at d+1, BUSY=0 at d+2.
- A new START is accepted no earlier than d+2.
- Row-to-row spacing per issuer is at least 2 cycles.

## Configuration
- Macro: STENCIL_DMA_PERF_EN.
- Defined:
  - CYCLES clears on START acceptance and increments every cycle BUSY=1.
  - CYCLES saturates at 0xFFFFFFFF.
  - CYCLES holds its value in IDLE.
- Undefined: the CYCLES port is present and tied to 0, and no counter logic is built.

## Structure
- Package stencil_dma_pkg holds:
  - the top-state enum and issuer-state enum;
  - ADDR_W=32 and CNT_W=16.
- Sub-module stencil_dma_row_issuer, instantiated twice (read, write).
  - Inputs: base, stride, count, rows, start, eligible, port BUSY.
  - Outputs: ADDR, COUNT, REQ, issued, done.

## Test plan
- ROWS=3, ROW_WORDS=64, SRC=0x1000, SRC_STRIDE=0x400, BUSY model 4 cycles -> READ_ADDR 0x1000, 0x1400, 0x1800; READ_COUNT=64; exactly one DONE.
- ROWS=0 -> DONE at t+1, READ_REQ and WRITE_REQ never asserted, BUSY low at t+2.
- WR_LAG=2, ROWS=5 -> WRITE_REQ for row i never precedes READ_REQ for row i+2; write rows 3 and 4 are issued after all reads; 5 of each REQ.
- FIFO_BUSY held high 20 cycles after the final REQ -> DONE exactly one cycle after FIFO_BUSY falls, not before.
- START pulsed during RUN is ignored (address sequence unchanged). RST at mid-row -> next cycle all outputs 0, no further REQ.
- SRC=0xFFFFFC00, SRC_STRIDE=0x400, ROWS=2 -> READ_ADDR 0xFFFFFC00 then 0x00000000. With STENCIL_DMA_PERF_EN, CYCLES equals the BUSY-high cycle count.

Source files
------------

// File: rtl/stencil_dma_pkg.sv
// Shared types and widths for the stencil row-sequencing DMA.
// Used by stencil_dma_seq and stencil_dma_row_issuer.
package stencil_dma_pkg;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } top_state_e;

  typedef enum logic [1:0] {
    I_IDLE,
    I_REQ,
    I_WAIT
  } iss_state_e;

endpackage

// File: rtl/stencil_dma_row_issuer.sv
// One-row-at-a-time request issuer: REQ, wait for port idle, step by stride.
// issued reports the count including a row completing this cycle.
module stencil_dma_row_issuer
  import stencil_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  rows,
  input  logic              start,
  input  logic              eligible,
  input  logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  cnt,
  output logic              req,
  output logic [CNT_W-1:0]  issued,
  output logic              done
);

  iss_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rows_q, rows_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              req_q, req_d;
  logic              leave;

  assign leave = (state_q == I_WAIT) && !busy;

  // Kept apart from the FSM so eligibility can see this cycle's count.
  always_comb begin
    issued_d = issued_q;
    if (start)
      issued_d = '0;
    else if (leave)
      issued_d = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    rows_d   = rows_q;
    if (start) begin
      addr_d   = base;
      stride_d = stride;
      cnt_d    = count;
      rows_d   = rows;
      state_d  = (eligible && !busy) ? I_REQ : I_IDLE;
    end else begin
      unique case (state_q)
        I_IDLE: begin
          if ((issued_q < rows_q) && eligible && !busy)
            state_d = I_REQ;
        end
        I_REQ: state_d = I_WAIT;
        I_WAIT: begin
          if (leave) begin
            addr_d  = addr_q + stride_q;
            state_d = ((issued_d < rows_q) && eligible) ? I_REQ : I_IDLE;
          end
        end
        default: state_d = I_IDLE;
      endcase
    end
    req_d = (state_d == I_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= I_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      rows_q   <= '0;
      issued_q <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      rows_q   <= rows_d;
      issued_q <= issued_d;
      req_q    <= req_d;
    end
  end

  assign addr   = addr_q;
  assign cnt    = cnt_q;
  assign req    = req_q;
  assign issued = issued_d;
  assign done   = (issued_q == rows_q);

endmodule

// File: rtl/stencil_dma_seq.sv
// 2-D descriptor row sequencer driving read/write request ports.
// Define STENCIL_DMA_PERF_EN to build the CYCLES busy-cycle counter.
module stencil_dma_seq
  import stencil_dma_pkg::*;
#(
  parameter int unsigned WR_LAG = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] SRC_ADDR,
  input  logic [31:0] DST_ADDR,
  input  logic [31:0] SRC_STRIDE,
  input  logic [31:0] DST_STRIDE,
  input  logic [15:0] ROW_WORDS,
  input  logic [15:0] ROWS,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] READ_ADDR,
  output logic [15:0] READ_COUNT,
  output logic        READ_REQ,
  input  logic        READ_BUSY,
  output logic [31:0] WRITE_ADDR,
  output logic [15:0] WRITE_COUNT,
  output logic        WRITE_REQ,
  input  logic        WRITE_BUSY,
  input  logic        FIFO_BUSY,
  output logic [31:0] CYCLES
);

  localparam logic [CNT_W:0] LAG_X = (CNT_W+1)'(WR_LAG);

  top_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept, go, all_idle;
  logic             rd_done, wr_done, wr_elig;
  logic [CNT_W-1:0] rd_iss, wr_iss;

  assign accept   = (state_q == S_IDLE) && START;
  assign go       = accept && (ROWS != '0) && (ROW_WORDS != '0);
  assign all_idle = !(READ_BUSY || WRITE_BUSY || FIFO_BUSY);

  // 17-bit compare so a large lag cannot wrap the write threshold.
  assign wr_elig = !go &&
    (rd_done || ({1'b0, rd_iss} > ({1'b0, wr_iss} + LAG_X)));

  stencil_dma_row_issuer u_rd (
    .clk      (CLK),
    .rst      (RST),
    .base     (SRC_ADDR),
    .stride   (SRC_STRIDE),
    .count    (ROW_WORDS),
    .rows     (ROWS),
    .start    (go),
    .eligible (1'b1),
    .busy     (READ_BUSY),
    .addr     (READ_ADDR),
    .cnt      (READ_COUNT),
    .req      (READ_REQ),
    .issued   (rd_iss),
    .done     (rd_done)
  );

  stencil_dma_row_issuer u_wr (
    .clk      (CLK),
    .rst      (RST),
    .base     (DST_ADDR),
    .stride   (DST_STRIDE),
    .count    (ROW_WORDS),
    .rows     (ROWS),
    .start    (go),
    .eligible (wr_elig),
    .busy     (WRITE_BUSY),
    .addr     (WRITE_ADDR),
    .cnt      (WRITE_COUNT),
    .req      (WRITE_REQ),
    .issued   (wr_iss),
    .done     (wr_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = go ? S_RUN : S_FIN;
      S_RUN:   if (rd_done && wr_done) state_d = S_DRAIN;
      S_DRAIN: if (all_idle) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;

`ifdef STENCIL_DMA_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (accept)
      cyc_d = '0;
    else if (busy_q && (cyc_q != 32'hFFFF_FFFF))
      cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign CYCLES = cyc_q;
`else
  assign CYCLES = '0;
`endif

endmodule

// File: tb/tb_stencil_dma_seq.sv
// Self-checking bench for stencil_dma_seq with port busy models.
// Expected rows come from base + i*stride and the write-lag rule.
module tb_stencil_dma_seq;

  localparam int LAG = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [31:0] SRC_ADDR = '0, DST_ADDR = '0;
  logic [31:0] SRC_STRIDE = '0, DST_STRIDE = '0;
  logic [15:0] ROW_WORDS = '0, ROWS = '0;
  logic        BUSY, DONE;
  logic [31:0] READ_ADDR, WRITE_ADDR;
  logic [15:0] READ_COUNT, WRITE_COUNT;
  logic        READ_REQ, WRITE_REQ;
  logic        READ_BUSY = 1'b0, WRITE_BUSY = 1'b0, FIFO_BUSY = 1'b0;
  logic [31:0] CYCLES;

  stencil_dma_seq #(.WR_LAG(LAG)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR),
    .SRC_STRIDE(SRC_STRIDE), .DST_STRIDE(DST_STRIDE),
    .ROW_WORDS(ROW_WORDS), .ROWS(ROWS),
    .BUSY(BUSY), .DONE(DONE),
    .READ_ADDR(READ_ADDR), .READ_COUNT(READ_COUNT),
    .READ_REQ(READ_REQ), .READ_BUSY(READ_BUSY),
    .WRITE_ADDR(WRITE_ADDR), .WRITE_COUNT(WRITE_COUNT),
    .WRITE_REQ(WRITE_REQ), .WRITE_BUSY(WRITE_BUSY),
    .FIFO_BUSY(FIFO_BUSY), .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [31:0] rdq[$];
  logic [31:0] wrq[$];
  logic [15:0] exp_words = '0;
  int  n_rows = 0, rd_idx = 0, wr_idx = 0, rd_cmp = 0;
  int  done_cnt = 0, bcnt = 0, fifo_fall = 0;
  int  fifo_hold = 0, busy_fix = 0;
  int  rd_left = 0, wr_left = 0, fifo_left = 0;
  bit  cur_nz = 0, rq_seen = 0, wq_seen = 0;
  bit  prev_rq = 0, prev_wq = 0, prev_idle = 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int blen();
    return (busy_fix > 0) ? busy_fix : int'($urandom_range(1, 5));
  endfunction

  // Port and FIFO responders: busy from the cycle after each REQ.
  always @(posedge CLK) begin
    bit pr, pf;
    #1;
    if (RST) begin
      rd_left = 0; wr_left = 0; fifo_left = 0;
      READ_BUSY = 0; WRITE_BUSY = 0; FIFO_BUSY = 0;
    end else begin
      pr = READ_BUSY;
      pf = FIFO_BUSY;
      if (rd_left > 0) rd_left--;
      if (wr_left > 0) wr_left--;
      if (fifo_left > 0) fifo_left--;
      if (rq_seen) begin rd_left = blen(); fifo_left = fifo_hold; end
      if (wq_seen) begin wr_left = blen(); fifo_left = fifo_hold; end
      READ_BUSY  = (rd_left > 0);
      WRITE_BUSY = (wr_left > 0);
      FIFO_BUSY  = (fifo_left > 0);
      if (pr && !READ_BUSY) rd_cmp++;
      if (pf && !FIFO_BUSY) fifo_fall = cyc;
    end
  end

  always @(negedge CLK) begin
    int need;
    if (RST) begin
      rq_seen = 0; wq_seen = 0; prev_rq = 0; prev_wq = 0; prev_idle = 1;
    end else begin
      if (READ_REQ) begin
        chk("rd_req_port_idle", READ_BUSY, 0);
        chk("rd_req_gap", prev_rq, 0);
        chk("rd_req_expected", rdq.size() != 0, 1);
        if (rdq.size() != 0) begin
          chk("rd_addr", READ_ADDR, rdq.pop_front());
          chk("rd_count", READ_COUNT, exp_words);
        end
        rd_idx++;
      end
      if (WRITE_REQ) begin
        chk("wr_req_port_idle", WRITE_BUSY, 0);
        chk("wr_req_gap", prev_wq, 0);
        chk("wr_req_expected", wrq.size() != 0, 1);
        if (wrq.size() != 0) begin
          chk("wr_addr", WRITE_ADDR, wrq.pop_front());
          chk("wr_count", WRITE_COUNT, exp_words);
        end
        need = (wr_idx + LAG + 1 < n_rows) ? wr_idx + LAG + 1 : n_rows;
        chk("wr_lag", rd_cmp >= need, 1);
        wr_idx++;
      end
      if (DONE) begin
        done_cnt++;
        if (cur_nz) chk("done_after_idle", prev_idle, 1);
      end
      if (BUSY) bcnt++;
      rq_seen = READ_REQ;
      wq_seen = WRITE_REQ;
      prev_rq = READ_REQ;
      prev_wq = WRITE_REQ;
      prev_idle = !(READ_BUSY || WRITE_BUSY || FIFO_BUSY);
    end
  end

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] sstr, input logic [31:0] dstr,
                          input logic [15:0] words, input logic [15:0] rows,
                          input int fhold, input bit poke);
    int t, dcyc, exp_cyc;
    bit got;
    cur_nz = (rows != 0) && (words != 0);
    n_rows = cur_nz ? int'(rows) : 0;
    rdq.delete();
    wrq.delete();
    for (int i = 0; i < n_rows; i++) begin
      rdq.push_back(src + sstr * 32'(i));
      wrq.push_back(dst + dstr * 32'(i));
    end
    exp_words = words;
    fifo_hold = fhold;
    @(negedge CLK);
    rd_idx = 0; wr_idx = 0; rd_cmp = 0; done_cnt = 0; bcnt = 0;
    SRC_ADDR = src; DST_ADDR = dst; SRC_STRIDE = sstr; DST_STRIDE = dstr;
    ROW_WORDS = words; ROWS = rows; START = 1;
    t = cyc;
    @(negedge CLK);
    START = 0;
    chk("busy_t1", BUSY, 1);
    if (cur_nz) chk("rd_req_t1", READ_REQ, 1);
    else        chk("done_t1", DONE, 1);
    got = 0;
    for (int k = 0; k < 3000; k++) begin
      if (DONE) begin got = 1; break; end
      if (poke && k == 4) begin START = 1; SRC_ADDR = ~src; ROWS = 0; end
      @(negedge CLK);
      START = 0; SRC_ADDR = src; ROWS = rows;
    end
    chk("done_seen", got, 1);
    dcyc = cyc;
    chk("busy_at_done", BUSY, 1);
    if (!cur_nz) chk("done_lat_zero", dcyc, t + 1);
    if (fhold >= 20) chk("done_after_fifo", dcyc, fifo_fall + 1);
    chk("rd_rows", rd_idx, n_rows);
    chk("wr_rows", wr_idx, n_rows);
    @(negedge CLK);
    chk("busy_off", BUSY, 0);
    chk("done_once", done_cnt, 1);
`ifdef STENCIL_DMA_PERF_EN
    exp_cyc = bcnt;
`else
    exp_cyc = 0;
`endif
    chk("cycles", CYCLES, exp_cyc);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_rreq"}, READ_REQ, 0);
    chk({tag, "_wreq"}, WRITE_REQ, 0);
    chk({tag, "_raddr"}, READ_ADDR, 0);
    chk({tag, "_rcnt"}, READ_COUNT, 0);
    chk({tag, "_waddr"}, WRITE_ADDR, 0);
    chk({tag, "_wcnt"}, WRITE_COUNT, 0);
    chk({tag, "_cycles"}, CYCLES, 0);
  endtask

  initial begin
    logic [31:0] s, d, ss, ds;
    logic [15:0] w, r;
    bit got;
    repeat (3) @(negedge CLK);
    check_zero_outputs("reset");
    RST = 0;
    @(negedge CLK);

    busy_fix = 4;
    run_xfer(32'h1000, 32'h8000, 32'h400, 32'h200, 16'd64, 16'd3, 0, 0);
    busy_fix = 0;
    run_xfer(32'h1000, 32'h8000, 32'h400, 32'h200, 16'd64, 16'd0, 0, 0);
    run_xfer(32'h2_0000, 32'h4_0000, 32'h100, 32'h80, 16'd16, 16'd5, 0, 0);
    run_xfer(32'h3000, 32'h5000, 32'h40, 32'h40, 16'd8, 16'd2, 20, 0);
    busy_fix = 3;
    run_xfer(32'h1000, 32'h9000, 32'h400, 32'h400, 16'd64, 16'd3, 0, 1);
    busy_fix = 0;
    run_xfer(32'hFFFF_FC00, 32'hFFFF_FF00, 32'h400, 32'h100,
             16'd4, 16'd2, 0, 0);

    for (int i = 0; i < 5; i++) begin
      s  = $urandom;
      d  = $urandom;
      ss = $urandom;
      ds = 32'($urandom_range(0, 4096));
      w  = (i == 1) ? 16'd0 : 16'($urandom_range(1, 300));
      r  = 16'($urandom_range(1, 7));
      run_xfer(s, d, ss, ds, w, r, int'($urandom_range(0, 3)), 0);
    end

    fifo_hold = 0;
    cur_nz = 1;
    n_rows = 4;
    rdq.delete();
    wrq.delete();
    for (int i = 0; i < 4; i++) begin
      rdq.push_back(32'h6000 + 32'h100 * 32'(i));
      wrq.push_back(32'h7000 + 32'h100 * 32'(i));
    end
    exp_words = 16'd8;
    busy_fix = 5;
    @(negedge CLK);
    rd_idx = 0; wr_idx = 0; rd_cmp = 0;
    SRC_ADDR = 32'h6000; DST_ADDR = 32'h7000;
    SRC_STRIDE = 32'h100; DST_STRIDE = 32'h100;
    ROW_WORDS = 16'd8; ROWS = 16'd4; START = 1;
    @(negedge CLK);
    START = 0;
    got = 0;
    for (int k = 0; k < 500; k++) begin
      if (rd_idx >= 2) begin got = 1; break; end
      @(negedge CLK);
    end
    chk("rst_reach_mid", got, 1);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    check_zero_outputs("abort");
    @(negedge CLK);
    rdq.delete();
    wrq.delete();
    rd_idx = 0;
    wr_idx = 0;
    cur_nz = 0;
    RST = 0;
    repeat (15) @(negedge CLK);
    chk("abort_no_rd_req", rd_idx, 0);
    chk("abort_no_wr_req", wr_idx, 0);
    chk("abort_idle", BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
